vram_scanout: RTL and testbench
===============================

# vram_scanout

Read-side counterpart of the VRAM write-port arbiter. It generates 640x480@60 VGA timing and issues one read per visible pixel to the frame-buffer read port (19-bit address, 16-bit RGB565 data). It converts each returned pixel to 12-bit RGB, aligned with registered HSYNC/VSYNC. It also exports a vertical-blank level so the write-side arbiter can time its switching.

## Interface
Parameters:
- PIX_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range >= 3
- RD_LAT, 1, VRAM read latency in clocks from rd_en cycle to valid rd_data; legal range 1 ≤ RD_LAT ≤ PIX_DIV-2

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  reset, asynchronous, active-high
- rd_en  output  1  read strobe, one cycle per visible pixel
- rd_addr  output  19  linear pixel address, y*640+x
- rd_data  input  16  RGB565 pixel, valid RD_LAT cycles after rd_en
- hs  output  1  horizontal sync, active-low
- vs  output  1  vertical sync, active-low
- r, g, b  output  4 each  pixel colour; 0 during blanking
- vblank  output  1  high while the displayed line is ≥ 480

## Operation
- Slot divider `div` counts 0..PIX_DIV-1 and wraps. One slot is one pixel position (h,v).
- h counts 0..799 and v counts 0..524. h advances on the edge ending div==PIX_DIV-1. When h wraps 799->0, v advances; v wraps 524->0.
- Horizontal regions: active 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical regions: active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Active position means h<640 and v<480.
- Address counter:
  - increments by 1 after each active position is issued
  - clears to 0 on the edge where (h,v) wraps from (799,524)
  - no multiplier
  - value at (639,479) is 307199; never exceeds it
- Read: for an active position, rd_en is high for exactly the cycle with div==1 and rd_addr holds that position's address. rd_en is low in every other cycle. rd_addr holds its last value when rd_en is low.
- Capture: rd_data is registered into a pixel holder at the end of cycle div==1+RD_LAT.
- Output stage, updated on the edge ending div==PIX_DIV-1, for the position just completed:
  - hs = 0 iff h in 656..751
  - vs = 0 iff v in 490..491
  - vblank = (v ≥ 480)
  - if active: r = d[15:12], g = d[10:7], b = d[4:1]
  - otherwise r, g, b = 0
- Consequence: display outputs lag the internal position by exactly one slot. hs, vs and colour stay mutually aligned.
- rd_data is ignored outside the capture cycle. No handshake or back-pressure exists: VRAM must honour RD_LAT every read.

## Timing
- Reset values: div=0, h=0, v=0, address=0, rd_en=0, rd_addr=0, hs=1, vs=1, r=g=b=0, vblank=0, pixel holder=0.
- Reset is asynchronous and takes effect immediately, including mid-line or mid-frame.
- After release, the first slot is (0,0); rd_en rises in the second clock after release (div==1).
- Latency from rd_en to the corresponding r/g/b change is PIX_DIV-1 clocks (3 at default).
- Line period is 800·PIX_DIV clocks (3200). Frame period is 525 lines (1,680,000 clocks).
- hs low width is 96·PIX_DIV clocks (384). vs low width is 2 lines (6400 clocks).
- Reads per frame: exactly 307,200. Per visible line: 640, spaced PIX_DIV clocks apart.

## Test plan
- Reset: assert rst for 5 clocks mid-frame -> all outputs take their reset values asynchronously, with no clock needed. After release, the first rd_en has rd_addr=0 and arrives two clocks after release.
- Address sequence: record the first line -> rd_addr = 0,1,…,639 at a 4-clock spacing, then no rd_en for 160 slots. The next line starts at 640. The last read of the frame is 307199, followed by 0 at the next frame.
- Sync timing: measure over 2 frames -> hs low 384 clocks every 3200 clocks. vs low 6400 clocks every 1,680,000 clocks. vblank high for 45 lines.
- Colour mapping (RD_LAT=1 memory model): return 16'hF81F -> r=F, g=0, b=F. Return 16'h07E0 -> r=0, g=F, b=0. Blanking pixels show 0 even when the model drives 16'hFFFF.
- Latency and alignment (RD_LAT=2 model): a pixel-valued ramp (data = address[15:0]) -> each rgb value matches the address read PIX_DIV-1 clocks earlier. The first visible pixel follows hs back porch by exactly 48 slots.
- Read exclusivity: over one frame -> rd_en is never high for two consecutive cycles, never high when h≥640 or v≥480, and has count 307,200.

Source files
------------

// File: rtl/vram_scanout.sv
// vram_scanout: read side of the frame buffer. Generates 640x480@60 raster
// timing from a divided system clock, fetches one RGB565 word per visible
// pixel from VRAM and presents it as 12-bit RGB with matching HSYNC/VSYNC.
// A vertical-blank level is exported for the write-side arbiter.
module vram_scanout #(
  parameter int PIX_DIV = 4,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_en,
  output logic [18:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        vblank
);

  // Divider width; PIX_DIV is at least 3 so this is never below 2 bits.
  localparam int DW = $clog2(PIX_DIV);

  // Divider phases: read issue, data capture and end of slot.
  localparam logic [DW-1:0] DIV_ISSUE = '0;
  localparam logic [DW-1:0] DIV_CAP   = DW'(1 + RD_LAT);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);

  // Horizontal raster geometry in pixel slots.
  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd751;
  localparam logic [9:0] H_LAST     = 10'd799;

  // Vertical raster geometry in lines.
  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd491;
  localparam logic [9:0] V_LAST     = 10'd524;

  // Address of the last visible pixel of a frame (639 + 479*640).
  localparam logic [18:0] ADDR_LAST = 19'd307199;

  // Raster position and slot divider.
  logic [DW-1:0] divCnt_q, divCnt_d;
  logic [9:0]    hCnt_q, hCnt_d;
  logic [9:0]    vCnt_q, vCnt_d;

  // Linear read address, built incrementally so no multiplier is needed.
  logic [18:0]   addrCnt_q, addrCnt_d;

  // Read port registers.
  logic          rdEn_q, rdEn_d;
  logic [18:0]   rdAddr_q, rdAddr_d;

  // Pixel holder for the word returned by VRAM.
  logic [15:0]   pix_q, pix_d;

  // Display output registers.
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          vblank_q, vblank_d;
  logic [3:0]    r_q, r_d;
  logic [3:0]    g_q, g_d;
  logic [3:0]    b_q, b_d;

  // Decoded control for the current cycle.
  logic          slotEnd;
  logic          frameWrap;
  logic          active;
  logic          issue;
  logic          capture;

  // Decode where the current cycle sits within the slot and the raster.
  always_comb begin
    slotEnd = (divCnt_q == DIV_LAST);
    active  = (hCnt_q < H_ACTIVE) && (vCnt_q < V_ACTIVE);
    issue   = (divCnt_q == DIV_ISSUE) && active;
    capture = (divCnt_q == DIV_CAP);
  end

  // Advance the divider every clock and the raster position once per slot.
  always_comb begin
    divCnt_d  = slotEnd ? '0 : divCnt_q + DW'(1);
    hCnt_d    = hCnt_q;
    vCnt_d    = vCnt_q;
    frameWrap = 1'b0;
    if (slotEnd) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = '0;
        if (vCnt_q == V_LAST) begin
          vCnt_d    = '0;
          frameWrap = 1'b1;
        end else begin
          vCnt_d = vCnt_q + 10'd1;
        end
      end else begin
        hCnt_d = hCnt_q + 10'd1;
      end
    end
  end

  // Step the address after each issued read, saturating at the last pixel
  // and restarting from zero when the frame wraps.
  always_comb begin
    addrCnt_d = addrCnt_q;
    if (frameWrap) begin
      addrCnt_d = '0;
    end else if (issue && (addrCnt_q != ADDR_LAST)) begin
      addrCnt_d = addrCnt_q + 19'd1;
    end
  end

  // Raise the read strobe for the div==1 cycle of a visible slot; the address
  // is held between reads so VRAM sees a stable bus.
  always_comb begin
    rdEn_d   = issue;
    rdAddr_d = issue ? addrCnt_q : rdAddr_q;
  end

  // Latch the returned pixel in the one cycle where VRAM guarantees it.
  always_comb begin
    pix_d = capture ? rd_data : pix_q;
  end

  // Produce sync, blank and colour for the slot that is just finishing;
  // pix_d is used so a capture in the last divider phase is still seen.
  always_comb begin
    hs_d     = hs_q;
    vs_d     = vs_q;
    vblank_d = vblank_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    if (slotEnd) begin
      hs_d     = !((hCnt_q >= H_SYNC_BEG) && (hCnt_q <= H_SYNC_END));
      vs_d     = !((vCnt_q >= V_SYNC_BEG) && (vCnt_q <= V_SYNC_END));
      vblank_d = (vCnt_q >= V_ACTIVE);
      if (active) begin
        r_d = pix_d[15:12];
        g_d = pix_d[10:7];
        b_d = pix_d[4:1];
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    end
  end

  // Timing counters and address generator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt_q  <= '0;
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      addrCnt_q <= '0;
    end else begin
      divCnt_q  <= divCnt_d;
      hCnt_q    <= hCnt_d;
      vCnt_q    <= vCnt_d;
      addrCnt_q <= addrCnt_d;
    end
  end

  // Read port and pixel holder state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdEn_q   <= 1'b0;
      rdAddr_q <= '0;
      pix_q    <= '0;
    end else begin
      rdEn_q   <= rdEn_d;
      rdAddr_q <= rdAddr_d;
      pix_q    <= pix_d;
    end
  end

  // Display output state; syncs idle high, colour black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vblank_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vblank_q <= vblank_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign rd_en   = rdEn_q;
  assign rd_addr = rdAddr_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign vblank  = vblank_q;
  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: two instances, one fed by a constant-colour VRAM
// model with a 1-clock latency, one fed by an address ramp with a 2-clock
// latency. Late-frame behaviour is reached by presetting the line and
// address counters of the first instance right after reset release.
module tb_vram_scanout;

  logic        clk;
  logic        rst;

  logic        rdEn1, rdEn2;
  logic [18:0] rdAddr1, rdAddr2;
  logic [15:0] rdData1, rdData2;
  logic        hs1, hs2, vs1, vs2, vblank1, vblank2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;

  logic [15:0] colourWord;
  logic        en2d;
  logic [18:0] a2d;

  int vectors;
  int miscompares;

  vram_scanout #(.PIX_DIV(4), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rdEn1), .rd_addr(rdAddr1), .rd_data(rdData1),
    .hs(hs1), .vs(vs1), .r(r1), .g(g1), .b(b1), .vblank(vblank1)
  );

  vram_scanout #(.PIX_DIV(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rdEn2), .rd_addr(rdAddr2), .rd_data(rdData2),
    .hs(hs2), .vs(vs2), .r(r2), .g(g2), .b(b2), .vblank(vblank2)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model with 1-clock latency returning a constant colour; all-ones
  // whenever no read data is due, so stray captures would show up.
  always @(posedge clk) begin
    rdData1 <= rdEn1 ? colourWord : 16'hFFFF;
  end

  // VRAM model with 2-clock latency returning the low address bits.
  always @(posedge clk) begin
    en2d    <= rdEn2;
    a2d     <= rdAddr2;
    rdData2 <= en2d ? a2d[15:0] : 16'hFFFF;
  end

  function automatic logic [11:0] map565(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  // Hold reset for a few clocks, release on a falling edge. The next falling
  // edge is cycle 0 of every scenario below (the first rd_en cycle).
  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset values and first read after release.
  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({rdEn1, rdAddr1, hs1, vs1, r1, g1, b1, vblank1} !== {1'b0, 19'd0, 1'b1, 1'b1, 12'h000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_async_state: got en=%0b addr=%0d hs=%0b vs=%0b rgb=%h vb=%0b, expected 0 0 1 1 000 0",
               rdEn1, rdAddr1, hs1, vs1, {r1, g1, b1}, vblank1);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({rdEn2, rdAddr2, hs2, vs2, r2, g2, b2, vblank2} !== {1'b0, 19'd0, 1'b1, 1'b1, 12'h000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state_lat2: got en=%0b addr=%0d hs=%0b vs=%0b rgb=%h vb=%0b, expected 0 0 1 1 000 0",
               rdEn2, rdAddr2, hs2, vs2, {r2, g2, b2}, vblank2);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (rdEn1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_no_read: got rd_en=%0b, expected 0", rdEn1);
    end
    @(negedge clk);
    vectors++;
    if (rdEn1 !== 1'b1 || rdAddr1 !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL first_read: got rd_en=%0b addr=%0d, expected 1 0", rdEn1, rdAddr1);
    end
  endtask

  // Address sequence, spacing and exclusivity over the first two lines.
  task automatic test_address();
    int  idx;
    int  expC;
    logic prevEn;
    colourWord = 16'hF81F;
    doReset();
    idx    = 0;
    prevEn = 1'b0;
    for (int c = 0; c < 6400; c++) begin
      @(negedge clk);
      if (rdEn1) begin
        expC = (idx % 640) * 4 + (idx / 640) * 3200;
        vectors++;
        if (rdAddr1 !== 19'(idx) || c != expC || prevEn) begin
          miscompares++;
          $display("[TB] FAIL addr_seq: got addr=%0d at cycle %0d (prev_en=%0b), expected addr=%0d at cycle %0d",
                   rdAddr1, c, prevEn, idx, expC);
        end
        idx++;
      end
      if (c == 2600) begin
        vectors++;
        if (rdEn1 !== 1'b0 || rdAddr1 !== 19'd639) begin
          miscompares++;
          $display("[TB] FAIL addr_hold: got en=%0b addr=%0d, expected 0 639", rdEn1, rdAddr1);
        end
      end
      prevEn = rdEn1;
    end
    vectors++;
    if (idx != 1280) begin
      miscompares++;
      $display("[TB] FAIL read_count_2lines: got %0d, expected 1280", idx);
    end
  endtask

  // Colour mapping of constant words and blanking suppression.
  task automatic test_colour();
    colourWord = 16'hF81F;
    doReset();
    for (int c = 0; c <= 2803; c++) begin
      @(negedge clk);
      if (c == 2) begin
        vectors++;
        if ({r1, g1, b1} !== 12'h000) begin
          miscompares++;
          $display("[TB] FAIL colour_before_first: got %h, expected 000", {r1, g1, b1});
        end
      end
      if (c == 3 || c == 2559) begin
        vectors++;
        if ({r1, g1, b1} !== 12'hF0F) begin
          miscompares++;
          $display("[TB] FAIL colour_F81F: cycle %0d got %h, expected F0F", c, {r1, g1, b1});
        end
      end
      if (c == 2563 || c == 2803) begin
        vectors++;
        if ({r1, g1, b1} !== 12'h000) begin
          miscompares++;
          $display("[TB] FAIL colour_blank: cycle %0d got %h, expected 000", c, {r1, g1, b1});
        end
      end
    end
    colourWord = 16'h07E0;
    doReset();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if ({r1, g1, b1} !== 12'h0F0) begin
          miscompares++;
          $display("[TB] FAIL colour_07E0: got %h, expected 0F0", {r1, g1, b1});
        end
      end
    end
    colourWord = 16'hF81F;
  endtask

  // HSYNC placement and width over two lines; back porch to first pixel.
  task automatic test_sync();
    int   nFall, nRise, lastRise, gap, vsBad;
    logic prevHs;
    doReset();
    nFall = 0; nRise = 0; lastRise = -1; gap = -1; vsBad = 0;
    prevHs = 1'b1;
    for (int c = 0; c < 6500; c++) begin
      @(negedge clk);
      if (prevHs && !hs1) begin
        vectors++;
        if (c != 2627 + 3200 * nFall) begin
          miscompares++;
          $display("[TB] FAIL hs_fall: got cycle %0d, expected %0d", c, 2627 + 3200 * nFall);
        end
        nFall++;
      end
      if (!prevHs && hs1) begin
        vectors++;
        if (c != 3011 + 3200 * nRise) begin
          miscompares++;
          $display("[TB] FAIL hs_rise: got cycle %0d, expected %0d", c, 3011 + 3200 * nRise);
        end
        nRise++;
        if (lastRise < 0) lastRise = c;
      end
      if (lastRise >= 0 && gap < 0 && {r2, g2, b2} !== 12'h000) gap = c - lastRise;
      if (vs1 !== 1'b1 || vblank1 !== 1'b0) vsBad++;
      prevHs = hs1;
    end
    vectors++;
    if (nFall != 2 || nRise != 2) begin
      miscompares++;
      $display("[TB] FAIL hs_edges: got falls=%0d rises=%0d, expected 2 2", nFall, nRise);
    end
    vectors++;
    if (gap != 192) begin
      miscompares++;
      $display("[TB] FAIL back_porch: got %0d clocks, expected 192", gap);
    end
    vectors++;
    if (vsBad != 0) begin
      miscompares++;
      $display("[TB] FAIL vs_vblank_active: got %0d bad cycles, expected 0", vsBad);
    end
  endtask

  // RD_LAT=2 ramp: colour changes exactly 3 clocks after each read.
  task automatic test_latency();
    logic [18:0] pendAddr, prevAddr;
    int  pendC;
    logic havePend;
    doReset();
    havePend = 1'b0;
    pendC = 0; pendAddr = '0; prevAddr = '0;
    for (int c = 0; c < 6400; c++) begin
      @(negedge clk);
      if (rdEn2) begin
        prevAddr = pendAddr;
        pendAddr = rdAddr2;
        pendC    = c;
        havePend = 1'b1;
      end
      if (havePend && c == pendC + 2 && (pendC % 3200) != 0) begin
        vectors++;
        if ({r2, g2, b2} !== map565(prevAddr[15:0])) begin
          miscompares++;
          $display("[TB] FAIL lat_early: cycle %0d got %h, expected %h", c, {r2, g2, b2}, map565(prevAddr[15:0]));
        end
      end
      if (havePend && c == pendC + 3) begin
        vectors++;
        if ({r2, g2, b2} !== map565(pendAddr[15:0])) begin
          miscompares++;
          $display("[TB] FAIL lat_ramp: addr %0d got %h, expected %h", pendAddr, {r2, g2, b2}, map565(pendAddr[15:0]));
        end
      end
    end
  endtask

  // Last visible line: reads up to 307199, held there, then vblank rises.
  task automatic test_frame_end();
    int n;
    doReset();
    force dut1.vCnt_q = 10'd479;
    force dut1.addrCnt_q = 19'd306560;
    #1;
    release dut1.vCnt_q;
    release dut1.addrCnt_q;
    n = 0;
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      if (rdEn1) begin
        vectors++;
        if (rdAddr1 !== 19'(306560 + n) || c != 4 * n) begin
          miscompares++;
          $display("[TB] FAIL last_line_addr: got addr=%0d at cycle %0d, expected %0d at %0d",
                   rdAddr1, c, 306560 + n, 4 * n);
        end
        n++;
      end
      if (c == 3000) begin
        vectors++;
        if (rdAddr1 !== 19'd307199) begin
          miscompares++;
          $display("[TB] FAIL last_addr_hold: got %0d, expected 307199", rdAddr1);
        end
      end
      if (c == 3202 || c == 3203) begin
        vectors++;
        if (vblank1 !== (c == 3203)) begin
          miscompares++;
          $display("[TB] FAIL vblank_rise: cycle %0d got %0b, expected %0b", c, vblank1, (c == 3203));
        end
      end
    end
    vectors++;
    if (n != 640) begin
      miscompares++;
      $display("[TB] FAIL last_line_count: got %0d, expected 640", n);
    end
  endtask

  // VSYNC low for lines 490-491, no reads in vertical blank.
  task automatic test_vsync();
    int   fallC, riseC, enCnt, vbBad;
    logic prevVs;
    doReset();
    force dut1.vCnt_q = 10'd489;
    force dut1.addrCnt_q = 19'd307199;
    #1;
    release dut1.vCnt_q;
    release dut1.addrCnt_q;
    fallC = -1; riseC = -1; enCnt = 0; vbBad = 0;
    prevVs = 1'b1;
    for (int c = 0; c < 9700; c++) begin
      @(negedge clk);
      if (prevVs && !vs1 && fallC < 0) fallC = c;
      if (!prevVs && vs1 && riseC < 0) riseC = c;
      if (rdEn1) enCnt++;
      if (c >= 3 && vblank1 !== 1'b1) vbBad++;
      prevVs = vs1;
    end
    vectors++;
    if (fallC != 3203 || riseC != 9603) begin
      miscompares++;
      $display("[TB] FAIL vs_window: got fall=%0d rise=%0d, expected 3203 9603", fallC, riseC);
    end
    vectors++;
    if (enCnt != 0) begin
      miscompares++;
      $display("[TB] FAIL vblank_reads: got %0d reads, expected 0", enCnt);
    end
    vectors++;
    if (vbBad != 0) begin
      miscompares++;
      $display("[TB] FAIL vblank_level: got %0d low cycles, expected 0", vbBad);
    end
  endtask

  // Frame wrap: line 524 is blank, then reads restart at address 0.
  task automatic test_frame_wrap();
    int firstC;
    logic [18:0] firstA;
    doReset();
    force dut1.vCnt_q = 10'd524;
    force dut1.addrCnt_q = 19'd307199;
    #1;
    release dut1.vCnt_q;
    release dut1.addrCnt_q;
    firstC = -1; firstA = '1;
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      if (rdEn1 && firstC < 0) begin
        firstC = c;
        firstA = rdAddr1;
      end
      if (c == 3202 || c == 3203) begin
        vectors++;
        if (vblank1 !== (c == 3202)) begin
          miscompares++;
          $display("[TB] FAIL vblank_fall: cycle %0d got %0b, expected %0b", c, vblank1, (c == 3202));
        end
      end
    end
    vectors++;
    if (firstC != 3200 || firstA !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL frame_wrap: got first read cycle %0d addr %0d, expected 3200 0", firstC, firstA);
    end
  endtask

  // Reset asserted mid-line clears outputs immediately without a clock.
  task automatic test_mid_reset();
    doReset();
    for (int c = 0; c <= 2556; c++) @(negedge clk);
    vectors++;
    if (rdEn1 !== 1'b1 || rdAddr1 !== 19'd639 || {r1, g1, b1} !== 12'hF0F) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_state: got en=%0b addr=%0d rgb=%h, expected 1 639 F0F",
               rdEn1, rdAddr1, {r1, g1, b1});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({rdEn1, rdAddr1, hs1, vs1, r1, g1, b1, vblank1} !== {1'b0, 19'd0, 1'b1, 1'b1, 12'h000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_async: got en=%0b addr=%0d hs=%0b vs=%0b rgb=%h vb=%0b, expected 0 0 1 1 000 0",
               rdEn1, rdAddr1, hs1, vs1, {r1, g1, b1}, vblank1);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (rdEn1 !== 1'b0 || rdAddr1 !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got en=%0b addr=%0d, expected 0 0", rdEn1, rdAddr1);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdEn1 !== 1'b1 || rdAddr1 !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_read: got en=%0b addr=%0d, expected 1 0", rdEn1, rdAddr1);
    end
  endtask

  // Scenario sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    colourWord  = 16'hF81F;
    test_reset();
    test_address();
    test_colour();
    test_sync();
    test_latency();
    test_frame_end();
    test_vsync();
    test_frame_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
